branch_rs_queue: RTL

- Parametrised branch reservation station and the next generation of the two-entry branch RS.
- DEPTH entries with NCDB-port common-data-bus wakeup, dispatch-cycle CDB bypass, and oldest-first select.
- A registered issue stage with valid/ready handshake feeds the branch unit.
- Sits between the dispatch/rename stage and the branch execution unit; flushed on commit of a mispredicted branch.

---
 rtl/branch_rs_queue.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/branch_rs_queue.sv
// Branch reservation station: DEPTH entries with multi-port CDB wakeup, dispatch-cycle bypass,
// age-matrix oldest-first select and a registered valid/ready issue stage.
module branch_rs_queue #(
   parameter  int WIDTH   = 31,
   parameter  int ROB     = 2,
   parameter  int C_WIDTH = 7,
   parameter  int DEPTH   = 4,
   parameter  int NCDB    = 2,
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int IW      = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        globalResetN,
   input  logic                        dispValid,
   output logic                        dispReady,
   input  logic signed [WIDTH:0]       value1,
   input  logic signed [WIDTH:0]       value2,
   input  logic                        ready1,
   input  logic                        ready2,
   input  logic [ROB:0]                rob1,
   input  logic [ROB:0]                rob2,
   input  logic [ROB:0]                robInstr,
   input  logic [C_WIDTH:0]            branchControl,
   input  logic [WIDTH:0]              predictedPC,
   input  logic [WIDTH:0]              address,
   input  logic [WIDTH:0]              seqPC,
   input  logic [NCDB-1:0]             cdbValid,
   input  logic [NCDB*(ROB+1)-1:0]     cdbRob,
   input  logic [NCDB*(WIDTH+1)-1:0]   cdbValue,
   input  logic                        flush,
   output logic                        issueValid,
   input  logic                        issueReady,
   output logic signed [WIDTH:0]       src1,
   output logic signed [WIDTH:0]       src2,
   output logic [C_WIDTH:0]            instrInfo,
   output logic [ROB:0]                instrRob,
   output logic [WIDTH:0]              predictedAddress,
   output logic [WIDTH:0]              targetAddress,
   output logic [WIDTH:0]              nxtPC,
   output logic [DEPTH-1:0]            busy,
   output logic [CW-1:0]               count
);

   logic [DEPTH-1:0] r_valid, r_rdy1, r_rdy2;
   logic [WIDTH:0]   r_v1 [DEPTH];
   logic [WIDTH:0]   r_v2 [DEPTH];
   logic [ROB:0]     r_tag1 [DEPTH];
   logic [ROB:0]     r_tag2 [DEPTH];
   logic [ROB:0]     r_rob [DEPTH];
   logic [C_WIDTH:0] r_ctl [DEPTH];
   logic [WIDTH:0]   r_pred [DEPTH];
   logic [WIDTH:0]   r_tgt [DEPTH];
   logic [WIDTH:0]   r_seq [DEPTH];
   // Row i, bit j set means entry i is older than entry j.
   logic [DEPTH-1:0] r_age [DEPTH];
   logic [CW-1:0]    r_count;

   logic             r_iss_valid;
   logic [WIDTH:0]   r_src1, r_src2, r_pred_o, r_tgt_o, r_nxt_o;
   logic [C_WIDTH:0] r_info;
   logic [ROB:0]     r_irob;

   logic [DEPTH-1:0] w_hit1, w_hit2, w_cand, w_sel;
   logic [WIDTH:0]   w_wv1 [DEPTH];
   logic [WIDTH:0]   w_wv2 [DEPTH];
   logic             w_dhit1, w_dhit2, w_disp, w_load, w_fire;
   logic [WIDTH:0]   w_dv1, w_dv2;
   logic [IW-1:0]    w_free_idx, w_sel_idx;

   // Lowest-numbered matching port wins because it is evaluated last.
   function automatic logic [WIDTH+1:0] cdb_lookup(input logic [ROB:0] tag,
                                                   input logic [NCDB-1:0] vld,
                                                   input logic [NCDB*(ROB+1)-1:0] tags,
                                                   input logic [NCDB*(WIDTH+1)-1:0] vals);
      logic [WIDTH+1:0] res;
      res = '0;
      for (int k = NCDB - 1; k >= 0; k--)
         if (vld[k] && tags[k*(ROB+1) +: ROB+1] == tag)
            res = {1'b1, vals[k*(WIDTH+1) +: WIDTH+1]};
      return res;
   endfunction

   // NOTE: every output of this block gets a default before the loops so no latch is inferred.
   always_comb begin
      w_free_idx = '0;
      w_sel_idx  = '0;
      w_cand     = r_valid & r_rdy1 & r_rdy2;
      for (int i = 0; i < DEPTH; i++) begin
         {w_hit1[i], w_wv1[i]} = cdb_lookup(r_tag1[i], cdbValid, cdbRob, cdbValue);
         {w_hit2[i], w_wv2[i]} = cdb_lookup(r_tag2[i], cdbValid, cdbRob, cdbValue);
         w_sel[i] = w_cand[i] & ~|(w_cand & ~r_age[i] & ~(DEPTH'(1) << i));
      end
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!r_valid[i]) w_free_idx = IW'(i);
      for (int i = 0; i < DEPTH; i++)
         if (w_sel[i]) w_sel_idx = IW'(i);
      {w_dhit1, w_dv1} = cdb_lookup(rob1, cdbValid, cdbRob, cdbValue);
      {w_dhit2, w_dv2} = cdb_lookup(rob2, cdbValid, cdbRob, cdbValue);
   end

   assign dispReady = (r_count < CW'(DEPTH));
   assign w_disp    = dispValid & dispReady & ~flush;
   assign w_load    = ~r_iss_valid | issueReady;
   assign w_fire    = w_load & (|w_cand) & ~flush;

   // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
   always_ff @(posedge clk or negedge globalResetN) begin
      if (!globalResetN) begin
         // NOTE: the entry file is a small flop array, so every field is reset rather than left as RAM.
         for (int i = 0; i < DEPTH; i++) begin
            r_v1[i]   <= '0;
            r_v2[i]   <= '0;
            r_tag1[i] <= '0;
            r_tag2[i] <= '0;
            r_rob[i]  <= '0;
            r_ctl[i]  <= '0;
            r_pred[i] <= '0;
            r_tgt[i]  <= '0;
            r_seq[i]  <= '0;
            r_age[i]  <= '0;
         end
         r_valid     <= '0;
         r_rdy1      <= '0;
         r_rdy2      <= '0;
         r_count     <= '0;
         r_iss_valid <= 1'b0;
         r_src1      <= '0;
         r_src2      <= '0;
         r_info      <= '1;
         r_irob      <= '0;
         r_pred_o    <= '0;
         r_tgt_o     <= '0;
         r_nxt_o     <= '0;
      end else if (flush) begin
         r_valid     <= '0;
         r_count     <= '0;
         r_iss_valid <= 1'b0;
         r_src1      <= '0;
         r_src2      <= '0;
         r_info      <= '1;
         r_irob      <= '0;
         r_pred_o    <= '0;
         r_tgt_o     <= '0;
         r_nxt_o     <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_rdy1[i] && w_hit1[i]) begin
               r_rdy1[i] <= 1'b1;
               r_v1[i]   <= w_wv1[i];
            end
            if (r_valid[i] && !r_rdy2[i] && w_hit2[i]) begin
               r_rdy2[i] <= 1'b1;
               r_v2[i]   <= w_wv2[i];
            end
         end
         if (w_load) begin
            r_iss_valid <= w_fire;
            if (w_fire) begin
               r_src1              <= r_v1[w_sel_idx];
               r_src2              <= r_v2[w_sel_idx];
               r_info              <= r_ctl[w_sel_idx];
               r_irob              <= r_rob[w_sel_idx];
               r_pred_o            <= r_pred[w_sel_idx];
               r_tgt_o             <= r_tgt[w_sel_idx];
               r_nxt_o             <= r_seq[w_sel_idx];
               r_valid[w_sel_idx]  <= 1'b0;
            end else begin
               r_src1   <= '0;
               r_src2   <= '0;
               r_info   <= '1;
               r_irob   <= '0;
               r_pred_o <= '0;
               r_tgt_o  <= '0;
               r_nxt_o  <= '0;
            end
         end
         // The free slot is never the one being issued, so both writes can share an edge.
         if (w_disp) begin
            r_valid[w_free_idx] <= 1'b1;
            r_rdy1[w_free_idx]  <= ready1 | w_dhit1;
            r_rdy2[w_free_idx]  <= ready2 | w_dhit2;
            r_v1[w_free_idx]    <= ready1 ? value1 : w_dv1;
            r_v2[w_free_idx]    <= ready2 ? value2 : w_dv2;
            r_tag1[w_free_idx]  <= rob1;
            r_tag2[w_free_idx]  <= rob2;
            r_rob[w_free_idx]   <= robInstr;
            r_ctl[w_free_idx]   <= branchControl;
            r_pred[w_free_idx]  <= predictedPC;
            r_tgt[w_free_idx]   <= address;
            r_seq[w_free_idx]   <= seqPC;
            for (int j = 0; j < DEPTH; j++) begin
               if (j == int'(w_free_idx)) r_age[j] <= '0;
               else                       r_age[j][w_free_idx] <= 1'b1;
            end
         end
         r_count <= r_count + CW'(w_disp) - CW'(w_fire);
      end
   end

   assign issueValid       = r_iss_valid;
   assign src1             = r_src1;
   assign src2             = r_src2;
   assign instrInfo        = r_info;
   assign instrRob         = r_irob;
   assign predictedAddress = r_pred_o;
   assign targetAddress    = r_tgt_o;
   assign nxtPC            = r_nxt_o;
   assign busy             = r_valid;
   assign count            = r_count;

endmodule
